// File: rtl/snake_ps2_pkg.sv
// Purpose : shared types and constants for the PS/2 host link of the snake game.
// Latency : n/a (types, constants and one pure function only).
// Flow    : n/a.
package snake_ps2_pkg;

  // Host transmitter FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_INHIBIT = 3'd1;
  localparam state_t ST_RTS     = 3'd2;
  localparam state_t ST_SHIFT   = 3'd3;
  localparam state_t ST_ACK     = 3'd4;
  localparam state_t ST_DONE    = 3'd5;
  localparam state_t ST_ERROR   = 3'd6;

  // Keyboard command / response bytes.
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Default timing at a 50 MHz clkin.
  localparam int DEF_INHIBIT_CYCLES = 6000;    // 120 us clock inhibit
  localparam int DEF_FIRST_TIMEOUT  = 750000;  // 15 ms to first device clock
  localparam int DEF_BIT_TIMEOUT    = 100000;  // 2 ms between device clocks

  // Frame as shifted out after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Purpose : 2-FF synchroniser for one raw PS/2 pin plus falling-edge detect.
// Latency : level valid 2 clkin after the pin moves; fall pulses one cycle at that point.
// Flow    : none, free-running sampler.
// Ports   : clkin/reset - system clock, async active-high reset
//           line_in     - raw pin level
//           level       - synchronised level
//           fall        - one-cycle pulse on a synchronised 1->0 transition
module ps2_line_sync (
  input  logic clkin,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic meta;
  logic now;
  logic prev;

  // Reset to 1: an idle PS/2 line floats high, so no false edge after reset.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      now  <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      now  <= meta;
      prev <= now;
    end
  end

  assign level = now;
  assign fall  = prev & ~now;

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose : PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
//           odd parity, stop, then samples the device ACK on the 11th clock.
// Latency : frame paced by the device clock; done/error one cycle after the end condition.
// Flow    : one byte per accepted send; send while busy is dropped, nothing is queued.
// Ports   : clkin, reset            - system clock, async active-high reset
//           send, data_in           - start request and byte, sampled only in IDLE
//           ps2_clk_in, ps2_dat_in  - raw pin levels
//           ps2_clk_oe, ps2_dat_oe  - 1 pulls the corresponding line low (open drain)
//           busy                    - frame in progress, receiver should ignore the line
//           done, ack_ok            - completion pulse, ack_ok=1 if the device ACKed
//           error                   - timeout pulse (no done in that case)
module ps2_host_tx
  import snake_ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int FIRST_TIMEOUT  = DEF_FIRST_TIMEOUT,
  parameter int BIT_TIMEOUT    = DEF_BIT_TIMEOUT
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  // One counter serves both the inhibit hold and the timeouts.
  localparam int MAX_TO  = (FIRST_TIMEOUT > BIT_TIMEOUT) ? FIRST_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_CYC = (MAX_TO > INHIBIT_CYCLES) ? MAX_TO : INHIBIT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] FIRST_LAST = CW'(FIRST_TIMEOUT - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_TIMEOUT - 1);

  state_t        state;
  logic [9:0]    frame;
  logic [3:0]    bit_idx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic          ack_seen;
  logic          timeout;

  logic clk_lvl, clk_fall;
  logic dat_lvl, dat_fall;
  logic sync_unused;

  ps2_line_sync u_clk_sync (
    .clkin   (clkin),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clkin   (clkin),
    .reset   (reset),
    .line_in (ps2_dat_in),
    .level   (dat_lvl),
    .fall    (dat_fall)
  );

  // Data-line edges carry no meaning for the host side.
  assign sync_unused = dat_fall;

  // Saturating increment: the counter never wraps back into a valid window.
  assign count_inc = (&count) ? count : count + 1'b1;

  // Only RTS waits on the long first-clock window; every later wait is per bit.
  assign timeout = (state == ST_RTS) ? (count == FIRST_LAST) : (count == BIT_LAST);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      frame      <= '0;
      bit_idx    <= '0;
      count      <= '0;
      ack_seen   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_ok     <= 1'b0;
      error      <= 1'b0;
    end else begin
      done   <= 1'b0;
      ack_ok <= 1'b0;
      error  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (send) begin
            frame      <= make_frame(data_in);
            bit_idx    <= '0;
            count      <= '0;
            ack_seen   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            state      <= ST_INHIBIT;
          end
        end

        // Clock held low; falls seen here are our own and are ignored.
        // dat_oe doubles as the "start bit cycle" marker.
        ST_INHIBIT: begin
          if (!ps2_dat_oe) begin
            if (count == INH_LAST) ps2_dat_oe <= 1'b1;
            else                   count      <= count_inc;
          end else begin
            ps2_clk_oe <= 1'b0;
            count      <= '0;
            state      <= ST_RTS;
          end
        end

        // RTS's first fall is fall 1 and drives data bit 0, same as SHIFT.
        ST_RTS, ST_SHIFT: begin
          if (clk_fall) begin
            ps2_dat_oe <= ~frame[bit_idx];
            bit_idx    <= bit_idx + 4'd1;
            count      <= '0;
            state      <= (bit_idx == 4'd9) ? ST_ACK : ST_SHIFT;
          end else if (timeout) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            state      <= ST_ERROR;
          end else begin
            count <= count_inc;
          end
        end

        ST_ACK: begin
          if (clk_fall) begin
            ack_seen <= ~dat_lvl;
            count    <= '0;
            state    <= ST_DONE;
          end else if (timeout) begin
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            state      <= ST_ERROR;
          end else begin
            count <= count_inc;
          end
        end

        // Wait for the device to let both lines float high before finishing.
        ST_DONE: begin
          if (clk_lvl && dat_lvl) begin
            done   <= 1'b1;
            ack_ok <= ack_seen;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end else if (timeout) begin
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            state      <= ST_ERROR;
          end else begin
            count <= count_inc;
          end
        end

        // error already pulsed on entry; one recovery cycle back to IDLE.
        ST_ERROR: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Purpose : randomized self-checking bench for ps2_host_tx with a PS/2 device model.
// Latency : n/a.
// Flow    : n/a.
module tb_ps2_host_tx;
  import snake_ps2_pkg::*;

  localparam int INH      = 600;
  localparam int FT       = 2000;
  localparam int BT       = 1000;
  localparam int SYNC_LAT = 3;   // pin change -> FSM reacts (2-FF sync + edge detect)

  logic       clkin = 1'b0;
  logic       reset;
  logic       send;
  logic [7:0] data_in;
  logic       dev_clk;
  logic       dev_dat;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, ack_ok, error;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int viol = 0;
  int exp_done = 0;
  int exp_err = 0;

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .FIRST_TIMEOUT  (FT),
    .BIT_TIMEOUT    (BT)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .send       (send),
    .data_in    (data_in),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .error      (error)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  always @(negedge clkin) begin
    if (!reset) begin
      if (done)  done_cnt <= done_cnt + 1;
      if (error) err_cnt  <= err_cnt + 1;
      if ((ps2_clk_oe || ps2_dat_oe) && !busy) viol <= viol + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line levels a device sees after falls 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones = 0;
    logic [9:0] f;
    for (int i = 0; i < 8; i++) begin
      f[i] = b[i];
      ones += int'(b[i]);
    end
    f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[9] = 1'b1;
    return f;
  endfunction

  // Accept a byte and check the inhibit / start-bit / RTS sequence.
  task automatic start_frame(input logic [7:0] b, output int t0);
    int inh = 0;
    @(negedge clkin);
    send = 1'b1;
    data_in = b;
    t0 = cyc;
    @(negedge clkin);
    send = 1'b0;
    data_in = 8'($urandom);
    chk_eq("busy_on_accept", {31'd0, busy}, 1);
    while (ps2_clk_oe && !ps2_dat_oe && inh < INH + 50) begin
      inh++;
      @(negedge clkin);
    end
    chk_eq("inhibit_len", inh, INH);
    chk_eq("start_bit_clk_held", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b11);
    @(negedge clkin);
    chk_eq("rts_clk_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 2'b01);
  endtask

  // Device model: waits for RTS, then generates nfalls clock pulses, sampling
  // the data line mid-low after each of falls 1..10; optionally ACKs.
  task automatic dev_run(input int nfalls, input bit ack, input int half,
                         output logic [9:0] seen, output int fall_cyc);
    bit rts_ok = 0;
    seen = '0;
    fall_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clkin);
      if (!ps2_clk_oe && ps2_dat_oe) begin
        rts_ok = 1;
        break;
      end
    end
    chk_eq("dev_saw_rts", {31'd0, rts_ok}, 1);
    if (!rts_ok) return;
    repeat (half) @(negedge clkin);
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk = 1'b0;
      fall_cyc = cyc;
      repeat (half / 2) @(negedge clkin);
      if (k <= 10) seen[k-1] = ps2_dat_in;
      repeat (half - half / 2) @(negedge clkin);
      dev_clk = 1'b1;
      if (k == 10 && ack) dev_dat = 1'b0;
      if (k == 11) dev_dat = 1'b1;
      if (k < nfalls) repeat (half) @(negedge clkin);
    end
  endtask

  task automatic wait_end(input int bound, output bit gd, output bit ge,
                          output logic ak, output logic bz, output int tc);
    gd = 0; ge = 0; ak = 1'b0; bz = 1'b1; tc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clkin);
      if (done || error) begin
        gd = done; ge = error; ak = ack_ok; bz = busy; tc = cyc;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input int half,
                           output logic [9:0] seen);
    int t0, fc, tc;
    bit gd, ge;
    logic ak, bz;
    start_frame(b, t0);
    dev_run(11, ack, half, seen, fc);
    chk_eq("frame_bits", {22'd0, seen}, {22'd0, ref_frame(b)});
    wait_end(50, gd, ge, ak, bz, tc);
    chk_eq("done_pulse", {30'd0, gd, ge}, 2'b10);
    chk_eq("ack_ok", {31'd0, ak}, {31'd0, ack});
    chk_eq("busy_drop_with_done", {31'd0, bz}, 0);
    exp_done++;
  endtask

  initial begin
    logic [9:0] seen;
    logic [7:0] b;
    int t0, fc, tc;
    bit gd, ge;
    logic ak, bz;

    reset = 1'b1; send = 1'b0; data_in = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
    #1;
    chk_eq("reset_outputs", {26'd0, ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error}, 0);
    repeat (3) @(negedge clkin);
    reset = 1'b0;
    repeat (3) @(negedge clkin);

    // Set-LEDs command, ACKed, 60-cycle device clock period.
    run_frame(CMD_SET_LEDS, 1'b1, 30, seen);
    chk_eq("ed_bits", {22'd0, seen}, 32'h3ED);

    // Parity 0 and parity 1 cases.
    run_frame(CMD_ENABLE, 1'b1, 25, seen);
    chk_eq("parity_f4", {31'd0, seen[8]}, 0);
    run_frame(8'h00, 1'b1, 25, seen);
    chk_eq("parity_00", {31'd0, seen[8]}, 1);

    // Device never clocks after RTS.
    start_frame(CMD_RESET, t0);
    wait_end(FT + 100, gd, ge, ak, bz, tc);
    chk_eq("first_to_pulse", {30'd0, gd, ge}, 2'b01);
    chk_eq("first_to_time", tc - t0, INH + FT + 2);
    chk_eq("first_to_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    chk_eq("first_to_busy", {31'd0, bz}, 0);
    exp_err++;
    repeat (5) @(negedge clkin);

    // Device stops after fall 5.
    start_frame(8'($urandom), t0);
    dev_run(5, 1'b0, 20, seen, fc);
    wait_end(BT + 100, gd, ge, ak, bz, tc);
    chk_eq("bit_to_pulse", {30'd0, gd, ge}, 2'b01);
    chk_eq("bit_to_time", tc - fc, BT + SYNC_LAT);
    chk_eq("bit_to_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    exp_err++;
    repeat (5) @(negedge clkin);

    // Data left high on fall 11: no ACK.
    run_frame(8'($urandom), 1'b0, 20, seen);

    // Reset mid-frame after fall 4 (0xA5 bit 3 = 0, so data is being pulled low).
    start_frame(8'hA5, t0);
    dev_run(4, 1'b0, 20, seen, fc);
    chk_eq("mid_frame_dat_low", {30'd0, ps2_dat_oe, busy}, 2'b11);
    reset = 1'b1;
    #1;
    chk_eq("reset_mid_frame", {29'd0, ps2_clk_oe, ps2_dat_oe, busy}, 0);
    repeat (2) @(negedge clkin);
    reset = 1'b0;
    repeat (3) @(negedge clkin);
    run_frame(8'($urandom), 1'b1, 20, seen);

    // send while busy: ignored, frame in flight unchanged, nothing queued.
    b = 8'($urandom);
    fork
      run_frame(b, 1'b1, 20, seen);
      begin
        repeat (INH + 150) @(negedge clkin);
        send = 1'b1;
        data_in = ~b;
        @(negedge clkin);
        send = 1'b0;
      end
    join
    repeat (30) @(negedge clkin);
    chk_eq("no_queued_frame", {30'd0, busy, ps2_clk_oe}, 0);

    // Random bytes, ACK choice and device clock rate.
    for (int n = 0; n < 6; n++) begin
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(15, 50), seen);
      repeat ($urandom_range(1, 20)) @(negedge clkin);
    end

    @(negedge clkin);
    chk_eq("done_count", done_cnt, exp_done);
    chk_eq("error_count", err_cnt, exp_err);
    chk_eq("oe_outside_busy", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
